// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-coverage sampler.
// Optional feature macro (see top): TOGGLE_COVER_ONESHOT_EN.
package toggle_cover_pkg;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    SETTLE = 2'd1,
    ARMED  = 2'd2
  } state_t;

  localparam int SETTLE_CYCLES_DEF = 4;

  // Cover point numbering: rise of bit i at 2*i, fall at 2*i+1.
  function automatic int pt_idx(input int bit_i, input logic is_fall);
    return 2 * bit_i + (is_fall ? 1 : 0);
  endfunction

  // Settle counter width, never narrower than one bit.
  function automatic int settle_cnt_w(input int settle_cycles);
    return (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/toggle_cover_sampler_if.sv
// Monitored-signal and coverage-output bundle for toggle_cover_sampler.
interface toggle_cover_sampler_if #(
  parameter int SIG_W = 21,
  parameter int CNT_W = 16
);
  logic               en;
  logic               clear;
  logic [SIG_W-1:0]   sig;
  logic [2*SIG_W-1:0] valid;
  logic               armed;
  logic [CNT_W-1:0]   hit_count;

  modport master (
    output en, clear, sig,
    input  valid, armed, hit_count
  );

  modport slave (
    input  en, clear, sig,
    output valid, armed, hit_count
  );
endinterface

// File: rtl/toggle_popcount.sv
// Combinational population count of an N-bit vector.
module toggle_popcount #(
  parameter int N = 42,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/toggle_cover_sampler.sv
// Per-bit rise/fall detector producing registered cover-point valids and a saturating hit count.
// Define TOGGLE_COVER_ONESHOT_EN to make each cover point report at most once until clear.
module toggle_cover_sampler
  import toggle_cover_pkg::*;
#(
  parameter int SIG_W         = 21,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = 16
) (
  input logic             clock,
  input logic             reset,
  toggle_cover_sampler_if.slave bus
);

  localparam int NPTS  = 2 * SIG_W;
  localparam int PW    = $clog2(NPTS + 1);
  localparam int SCW   = settle_cnt_w(SETTLE_CYCLES);
  localparam int SUM_W = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t            state;
  state_t            state_next;
  logic [SCW-1:0]    settle_cnt;
  logic [SCW-1:0]    settle_cnt_next;
  logic [SIG_W-1:0]  prev_q;
  logic [NPTS-1:0]   events;
  logic [NPTS-1:0]   mask;
  logic [NPTS-1:0]   valid_next;
  logic [NPTS-1:0]   valid_q;
  logic [PW-1:0]     pop;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  hit_sat;
  logic [CNT_W-1:0]  hit_q;

  always_comb begin
    events = '0;
    for (int i = 0; i < SIG_W; i++) begin
      events[pt_idx(i, 1'b0)] = bus.sig[i] & ~prev_q[i];
      events[pt_idx(i, 1'b1)] = ~bus.sig[i] & prev_q[i];
    end
  end

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    case (state)
      PRIME: begin
        settle_cnt_next = '0;
        state_next      = (SETTLE_CYCLES == 0) ? ARMED : SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = ARMED;
        end else begin
          settle_cnt_next = settle_cnt + SCW'(1);
        end
      end
      ARMED:   state_next = ARMED;
      default: state_next = PRIME;
    endcase
  end

  assign valid_next = (state == ARMED && bus.en) ? (events & ~mask) : '0;

  toggle_popcount #(.N(NPTS), .W(PW)) u_popcount (
    .bits  (valid_next),
    .count (pop)
  );

  // Widened sum so the saturation test never sees a wrapped value.
  always_comb begin
    sum     = SUM_W'(hit_q) + SUM_W'(pop);
    hit_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= PRIME;
      settle_cnt <= '0;
      prev_q     <= '0;
      valid_q    <= '0;
      hit_q      <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      prev_q     <= bus.sig;
      valid_q    <= valid_next;
      hit_q      <= bus.clear ? '0 : hit_sat;
    end
  end

`ifdef TOGGLE_COVER_ONESHOT_EN
  // Sticky record of reported points; clear wins over same-cycle hits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else if (bus.clear) begin
      mask <= '0;
    end else begin
      mask <= mask | valid_next;
    end
  end
`else
  assign mask = '0;
`endif

  assign bus.valid     = valid_q;
  assign bus.armed     = (state == ARMED);
  assign bus.hit_count = hit_q;

endmodule

// File: tb/tb_toggle_cover_sampler.sv
// Randomised and directed checks of toggle_cover_sampler against a spec-level model.
module tb_toggle_cover_sampler;

  localparam int SIG_W  = 21;
  localparam int NPTS   = 2 * SIG_W;
  localparam int SETTLE = 4;
  localparam int MAX_BIG   = 65535;
  localparam int MAX_SMALL = 3;
`ifdef TOGGLE_COVER_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic clock;
  logic reset;

  toggle_cover_sampler_if #(.SIG_W(SIG_W), .CNT_W(16)) bus ();
  toggle_cover_sampler_if #(.SIG_W(SIG_W), .CNT_W(2))  bus_s ();

  assign bus_s.en    = bus.en;
  assign bus_s.clear = bus.clear;
  assign bus_s.sig   = bus.sig;

  toggle_cover_sampler #(.SIG_W(SIG_W), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  toggle_cover_sampler #(.SIG_W(SIG_W), .SETTLE_CYCLES(SETTLE), .CNT_W(2)) dut_small (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run;
  int tests_failed;

  // Reference model state
  int              edge_no;
  logic [SIG_W-1:0] m_prev;
  bit              covered [NPTS];
  logic [NPTS-1:0] exp_valid;
  int              exp_count;
  int              exp_count_s;
  bit              exp_armed;

  task automatic model_reset();
    edge_no     = 0;
    m_prev      = '0;
    exp_valid   = '0;
    exp_count   = 0;
    exp_count_s = 0;
    exp_armed   = 1'b0;
    for (int p = 0; p < NPTS; p++) covered[p] = 1'b0;
  endtask

  // One clock edge: the model sees the inputs held across the edge, then sampling happens 1ns later.
  task automatic tick();
    bit det;
    bit ev;
    int hits;
    logic [NPTS-1:0] v;
    @(posedge clock);
    edge_no++;
    det  = bus.en && (edge_no >= SETTLE + 2);
    hits = 0;
    v    = '0;
    for (int p = 0; p < NPTS; p++) begin
      int b;
      b  = p / 2;
      ev = (p % 2 == 0) ? (bus.sig[b] && !m_prev[b]) : (!bus.sig[b] && m_prev[b]);
      if (ev && det && !(ONESHOT && covered[p])) begin
        v[p] = 1'b1;
        hits++;
      end
    end
    if (bus.clear) begin
      exp_count   = 0;
      exp_count_s = 0;
      for (int p = 0; p < NPTS; p++) covered[p] = 1'b0;
    end else begin
      exp_count   = (exp_count + hits > MAX_BIG) ? MAX_BIG : exp_count + hits;
      exp_count_s = (exp_count_s + hits > MAX_SMALL) ? MAX_SMALL : exp_count_s + hits;
      for (int p = 0; p < NPTS; p++) if (v[p]) covered[p] = 1'b1;
    end
    exp_valid = v;
    m_prev    = bus.sig;
    exp_armed = (edge_no >= SETTLE + 1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (bus.valid !== '0) begin tests_failed++; $display("[TB] FAIL reset_valid got %h want 0", bus.valid); end
    tests_run++;
    if (bus.armed !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_armed got %b want 0", bus.armed); end
    tests_run++;
    if (bus.hit_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_hit got %0d want 0", bus.hit_count); end
    tests_run++;
    if (bus_s.hit_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_hit_small got %0d want 0", bus_s.hit_count); end
    reset = 1'b0;
  endtask

  task automatic test_arming();
    bus.sig = '0;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      tick();
      tests_run++;
      if (bus.armed !== (k >= SETTLE + 1)) begin
        tests_failed++; $display("[TB] FAIL arm_edge%0d armed got %b want %b", k, bus.armed, (k >= SETTLE + 1));
      end
      tests_run++;
      if (bus.valid !== '0) begin tests_failed++; $display("[TB] FAIL arm_valid%0d got %h want 0", k, bus.valid); end
    end
  endtask

  task automatic test_single_toggle();
    bus.sig = 21'h1;
    tick();
    tests_run++;
    if (bus.valid !== 42'h1) begin tests_failed++; $display("[TB] FAIL rise_valid got %h want %h", bus.valid, 42'h1); end
    tick();
    tests_run++;
    if (bus.valid !== '0) begin tests_failed++; $display("[TB] FAIL rise_oneshot got %h want 0", bus.valid); end
    bus.sig = 21'h0;
    tick();
    tests_run++;
    if (bus.valid !== 42'h2) begin tests_failed++; $display("[TB] FAIL fall_valid got %h want %h", bus.valid, 42'h2); end
    tests_run++;
    if (bus.hit_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL toggle_hit got %0d want 2", bus.hit_count); end
  endtask

  task automatic test_settle_toggles();
    logic [SIG_W-1:0] seq [6];
    seq[0] = 21'h0; seq[1] = 21'h3; seq[2] = 21'h0;
    seq[3] = 21'h3; seq[4] = 21'h3; seq[5] = 21'h0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.sig = seq[k];
      tick();
      tests_run++;
      if (bus.valid !== '0) begin tests_failed++; $display("[TB] FAIL settle_valid%0d got %h want 0", k, bus.valid); end
    end
    tests_run++;
    if (bus.armed !== 1'b1) begin tests_failed++; $display("[TB] FAIL settle_armed got %b want 1", bus.armed); end
    bus.sig = seq[5];
    tick();
    tests_run++;
    if (bus.valid !== 42'hA) begin tests_failed++; $display("[TB] FAIL armed_fall got %h want %h", bus.valid, 42'hA); end
    tests_run++;
    if (bus.hit_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL armed_fall_hit got %0d want 2", bus.hit_count); end
  endtask

  task automatic test_oneshot();
    int want_big;
    int want_small;
    pulse_clear();
    tests_run++;
    if (bus.hit_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL clear_hit got %0d want 0", bus.hit_count); end
    for (int k = 0; k < 10; k++) begin
      bus.sig = bus.sig ^ 21'h1;
      tick();
      tests_run++;
      if (bus.valid !== exp_valid) begin
        tests_failed++; $display("[TB] FAIL bit0_toggle%0d valid got %h want %h", k, bus.valid, exp_valid);
      end
    end
    want_big   = ONESHOT ? 2 : 10;
    want_small = ONESHOT ? 2 : 3;
    tests_run++;
    if (bus.hit_count !== 16'(want_big)) begin
      tests_failed++; $display("[TB] FAIL bit0_hit got %0d want %0d", bus.hit_count, want_big);
    end
    tests_run++;
    if (bus_s.hit_count !== 2'(want_small)) begin
      tests_failed++; $display("[TB] FAIL bit0_hit_small got %0d want %0d", bus_s.hit_count, want_small);
    end
    pulse_clear();
    bus.sig = 21'h1;
    tick();
    tests_run++;
    if (bus.valid !== 42'h1) begin tests_failed++; $display("[TB] FAIL reappear_rise got %h want %h", bus.valid, 42'h1); end
    bus.sig = 21'h0;
    tick();
    tests_run++;
    if (bus.valid !== 42'h2) begin tests_failed++; $display("[TB] FAIL reappear_fall got %h want %h", bus.valid, 42'h2); end
    tests_run++;
    if (bus.hit_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL reappear_hit got %0d want 2", bus.hit_count); end
  endtask

  task automatic test_enable();
    bus.en  = 1'b0;
    bus.sig = 21'h20;
    tick();
    tests_run++;
    if (bus.valid !== '0) begin tests_failed++; $display("[TB] FAIL en_low_valid got %h want 0", bus.valid); end
    tests_run++;
    if (bus.hit_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL en_low_hit got %0d want 2", bus.hit_count); end
    bus.en = 1'b1;
    tick();
    tests_run++;
    if (bus.valid !== '0) begin tests_failed++; $display("[TB] FAIL en_consumed got %h want 0", bus.valid); end
    bus.sig = 21'h0;
    tick();
    tests_run++;
    if (bus.valid !== 42'h800) begin tests_failed++; $display("[TB] FAIL en_fall5 got %h want %h", bus.valid, 42'h800); end
    tests_run++;
    if (bus.hit_count !== 16'd3) begin tests_failed++; $display("[TB] FAIL en_fall5_hit got %0d want 3", bus.hit_count); end
  endtask

  task automatic test_saturation();
    pulse_clear();
    for (int k = 1; k <= 5; k++) begin
      bus.sig = SIG_W'((1 << k) - 1);
      tick();
      tests_run++;
      if (bus_s.hit_count !== 2'((k > 3) ? 3 : k)) begin
        tests_failed++; $display("[TB] FAIL sat_small%0d got %0d want %0d", k, bus_s.hit_count, (k > 3) ? 3 : k);
      end
    end
    tests_run++;
    if (bus.hit_count !== 16'd5) begin tests_failed++; $display("[TB] FAIL sat_big got %0d want 5", bus.hit_count); end
    // Assert reset between edges: outputs must drop before any clock arrives.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (bus.valid !== '0) begin tests_failed++; $display("[TB] FAIL midrst_valid got %h want 0", bus.valid); end
    tests_run++;
    if (bus.armed !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_armed got %b want 0", bus.armed); end
    tests_run++;
    if (bus.hit_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL midrst_hit got %0d want 0", bus.hit_count); end
    tests_run++;
    if (bus_s.hit_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL midrst_hit_small got %0d want 0", bus_s.hit_count); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= SETTLE + 1; k++) begin
      tick();
      tests_run++;
      if (bus.armed !== (k >= SETTLE + 1)) begin
        tests_failed++; $display("[TB] FAIL rearm_edge%0d armed got %b want %b", k, bus.armed, (k >= SETTLE + 1));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      bus.sig   = SIG_W'($urandom);
      bus.en    = ($urandom_range(0, 7) != 0);
      bus.clear = ($urandom_range(0, 15) == 0);
      tick();
      tests_run++;
      if (bus.valid !== exp_valid) begin
        tests_failed++; $display("[TB] FAIL rnd%0d valid got %h want %h", n, bus.valid, exp_valid);
      end
      tests_run++;
      if (bus.armed !== exp_armed) begin
        tests_failed++; $display("[TB] FAIL rnd%0d armed got %b want %b", n, bus.armed, exp_armed);
      end
      tests_run++;
      if (bus.hit_count !== 16'(exp_count)) begin
        tests_failed++; $display("[TB] FAIL rnd%0d hit got %0d want %0d", n, bus.hit_count, exp_count);
      end
      tests_run++;
      if (bus_s.hit_count !== 2'(exp_count_s)) begin
        tests_failed++; $display("[TB] FAIL rnd%0d hit_small got %0d want %0d", n, bus_s.hit_count, exp_count_s);
      end
    end
    bus.en    = 1'b1;
    bus.clear = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.clear    = 1'b0;
    bus.sig      = '0;
    model_reset();
    test_reset();
    test_arming();
    test_single_toggle();
    test_settle_toggles();
    test_oneshot();
    test_enable();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
